sample_streamer: RTL and testbench

SAMPLE_STREAMER -- requirements
Module: sample_streamer

---
 rtl/dataset_pkg.sv | 19 +
 rtl/row_serializer.sv | 42 ++++
 rtl/sample_streamer.sv | 101 ++++++++++
 tb/tb_sample_streamer.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/dataset_pkg.sv
// dataset_pkg: shared constants, FSM encoding and feature-count clamp for the sample streamer
package dataset_pkg;
  localparam int DEF_ADDR_WIDTH   = 12;
  localparam int DEF_MAX_FEATURES = 15;
  localparam int DEF_WORD_W       = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_LOAD,
    S_STREAM,
    S_DONE
  } state_t;

  function automatic int unsigned clamp_nf(input logic [3:0] nf, input int unsigned max_f);
    return (32'(nf) > max_f) ? max_f : 32'(nf);
  endfunction
endpackage

// File: rtl/row_serializer.sv
// row_serializer: holds one RAM row and walks its feature words followed by the y word
module row_serializer
  import dataset_pkg::*;
#(
  parameter int MAX_FEATURES = DEF_MAX_FEATURES,
  parameter int WORD_W       = DEF_WORD_W,
  parameter int ROW_W        = WORD_W*(MAX_FEATURES+1),
  parameter int SEL_W        = $clog2(MAX_FEATURES+1)
)(
  input  logic              CLK,
  input  logic              RST,
  input  logic              load,
  input  logic              advance,
  input  logic [SEL_W-1:0]  nf,
  input  logic [ROW_W-1:0]  row_in,
  output logic [WORD_W-1:0] word,
  output logic              eos
);
  logic [ROW_W-1:0] row_q, row_d;
  logic [SEL_W-1:0] idx_q, idx_d, sel;

  assign eos  = idx_q == nf;
  assign sel  = eos ? SEL_W'(MAX_FEATURES) : idx_q;
  assign word = row_q[int'(sel)*WORD_W +: WORD_W];

  // a load restarts at feature 0; each accepted word steps, and the y word wraps back to 0
  always_comb begin
    row_d = load ? row_in : row_q;
    idx_d = load ? '0 : advance ? (eos ? '0 : idx_q + 1'b1) : idx_q;
  end

  // row and word-index registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      row_q <= '0;
      idx_q <= '0;
    end else begin
      row_q <= row_d;
      idx_q <= idx_d;
    end
  end
endmodule

// File: rtl/sample_streamer.sv
// sample_streamer: fetches dataset rows from RAM one at a time and streams features then y
module sample_streamer
  import dataset_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int MAX_FEATURES = DEF_MAX_FEATURES,
  parameter int WORD_W       = DEF_WORD_W,
  parameter int ROW_W        = WORD_W*(MAX_FEATURES+1)
)(
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] num_points,
  input  logic [3:0]            num_features,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_oe,
  output logic                  ram_we,
  input  logic [ROW_W-1:0]      ram_data,
  output logic [WORD_W-1:0]     out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_eos,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);
  localparam int SEL_W = $clog2(MAX_FEATURES+1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] row_cnt_q, row_cnt_d, npts_q, npts_d;
  logic [SEL_W-1:0]      nf_q, nf_d;
  logic [WORD_W-1:0]     word;
  logic                  eos, last_row, accept;

  assign last_row  = row_cnt_q == npts_q - 1'b1;
  assign out_valid = state_q == S_STREAM;
  assign accept    = out_valid && out_ready;
  assign ram_oe    = state_q inside {S_ADDR, S_WAIT, S_LOAD};
  assign ram_addr  = ram_oe ? row_cnt_q : '0;
  assign ram_we    = 1'b0;
  assign out_data  = out_valid ? word : '0;
  assign out_eos   = out_valid && eos;
  assign out_last  = out_eos && last_row;
  assign busy      = state_q != S_IDLE;
  assign done      = state_q == S_DONE;

  row_serializer #(
    .MAX_FEATURES(MAX_FEATURES),
    .WORD_W      (WORD_W),
    .ROW_W       (ROW_W),
    .SEL_W       (SEL_W)
  ) u_ser (
    .CLK    (CLK),
    .RST    (RST),
    .load   (state_q == S_LOAD),
    .advance(accept),
    .nf     (nf_q),
    .row_in (ram_data),
    .word   (word),
    .eos    (eos)
  );

  // sequencing: latch the job on start, fetch a row, stream it, repeat until the last y word
  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    npts_d    = npts_q;
    nf_d      = nf_q;
    case (state_q)
      S_IDLE: if (start) begin
        npts_d    = num_points;
        nf_d      = SEL_W'(clamp_nf(num_features, MAX_FEATURES));
        row_cnt_d = '0;
        state_d   = num_points == '0 ? S_DONE : S_ADDR;
      end
      S_ADDR:   state_d = S_WAIT;
      S_WAIT:   state_d = S_LOAD;
      S_LOAD:   state_d = S_STREAM;
      S_STREAM: if (accept && eos) begin
        state_d   = last_row ? S_DONE : S_ADDR;
        row_cnt_d = last_row ? row_cnt_q : row_cnt_q + 1'b1;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  // state, row counter and latched job parameters
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      row_cnt_q <= '0;
      npts_q    <= '0;
      nf_q      <= '0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      npts_q    <= npts_d;
      nf_q      <= nf_d;
    end
  end
endmodule

// File: tb/tb_sample_streamer.sv
// tb_sample_streamer: table-driven scoreboard bench for the sample streamer
module tb_sample_streamer;
  localparam int AW = 12, MF = 15, WW = 16, RW = WW*(MF+1), BUDGET = 300;

  logic          CLK = 1'b0, RST = 1'b1, start = 1'b0, out_ready = 1'b0;
  logic [AW-1:0] num_points = '0;
  logic [3:0]    num_features = '0;
  logic [AW-1:0] ram_addr;
  logic          ram_oe, ram_we;
  logic [RW-1:0] ram_data;
  logic [WW-1:0] out_data;
  logic          out_valid, out_eos, out_last, busy, done;
  int            total = 0, bad = 0;

  typedef struct {logic [WW-1:0] data; logic eos; logic last;} exp_t;
  typedef struct {int np; int nf; int stall; int restart; int rnd; int words;} vec_t;
  exp_t q[$];
  vec_t vecs[7];

  always #5 CLK = ~CLK;

  sample_streamer dut (
    .CLK(CLK), .RST(RST), .start(start), .num_points(num_points), .num_features(num_features),
    .ram_addr(ram_addr), .ram_oe(ram_oe), .ram_we(ram_we), .ram_data(ram_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_eos(out_eos), .out_last(out_last), .busy(busy), .done(done)
  );

  function automatic logic [WW-1:0] word_of(input int r, input int k);
    return {8'(r + 64), 4'(k), 4'hE};
  endfunction

  always_comb begin
    ram_data = '0;
    for (int k = 0; k <= MF; k++) ram_data[WW*k +: WW] = word_of(int'(ram_addr), k);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int nfc, acc, stall_left, first_valid, done_cyc, ndone, oe_seen, we_seen;
    bit fin;
    nfc = v.nf > MF ? MF : v.nf;
    q.delete();
    for (int r = 0; r < v.np; r++) begin
      for (int k = 0; k < nfc; k++) q.push_back('{word_of(r, k), 1'b0, 1'b0});
      q.push_back('{word_of(r, MF), 1'b1, r == v.np - 1});
    end
    acc = 0; stall_left = 5; first_valid = -1; done_cyc = -1; ndone = 0;
    oe_seen = 0; we_seen = 0; fin = 0;
    @(negedge CLK);
    num_points = AW'(v.np); num_features = 4'(v.nf); start = 1'b1; out_ready = 1'b1;
    for (int cyc = 1; cyc <= BUDGET && !fin; cyc++) begin
      @(negedge CLK);
      start = cyc == v.restart;
      if (start) num_points = AW'(v.np + 5);
      if (v.rnd != 0) out_ready = $urandom_range(0, 3) != 0;
      else out_ready = !(out_valid && acc == v.stall && stall_left > 0);
      if (v.rnd == 0 && out_valid && !out_ready) stall_left--;
      if (ram_oe) oe_seen++;
      if (ram_we) we_seen++;
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (out_valid) begin
        if (q.size() == 0) chk("extra_word", 32'(out_valid), 32'd0);
        else begin
          chk("data", 32'(out_data), 32'(q[0].data));
          chk("eos", 32'(out_eos), 32'(q[0].eos));
          chk("last", 32'(out_last), 32'(q[0].last));
          if (out_ready) begin
            void'(q.pop_front());
            acc++;
          end
        end
      end
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && !done) fin = 1;
    end
    chk("timeout", 32'(fin), 32'd1);
    chk("busy_after", 32'(busy), 32'd0);
    chk("done_pulses", ndone, 1);
    chk("words", acc, v.words);
    chk("queue_left", q.size(), 0);
    chk("ram_we", we_seen, 0);
    chk("first_valid", first_valid, v.np == 0 ? -1 : 4);
    if (v.np == 0) begin
      chk("oe_seen", oe_seen, 0);
      chk("done_by_2", 32'(done_cyc >= 1 && done_cyc <= 2), 32'd1);
    end
  endtask

  initial begin
    int wait_cyc;
    vecs[0] = '{2, 3, -1, 0, 0, 8};
    vecs[1] = '{2, 3, 1, 0, 0, 8};
    vecs[2] = '{1, 15, -1, 0, 0, 16};
    vecs[3] = '{3, 0, -1, 0, 0, 3};
    vecs[4] = '{0, 5, -1, 0, 0, 0};
    vecs[5] = '{2, 1, -1, 6, 0, 4};
    vecs[6] = '{4, 7, -1, 0, 1, 32};
    repeat (3) @(negedge CLK);
    chk("rst_oe_we", {30'd0, ram_oe, ram_we}, 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("rst_out", {13'd0, out_valid, out_eos, out_last, out_data}, 32'd0);
    chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
    RST = 1'b0;
    foreach (vecs[i]) run_vec(vecs[i]);
    @(negedge CLK);
    num_points = AW'(3); num_features = 4'd4; start = 1'b1; out_ready = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    wait_cyc = 0;
    while (!out_valid && wait_cyc < 20) begin
      @(negedge CLK);
      wait_cyc++;
    end
    chk("mid_valid", 32'(out_valid), 32'd1);
    repeat (2) @(negedge CLK);
    chk("mid_busy", 32'(busy), 32'd1);
    RST = 1'b1;
    @(negedge CLK);
    chk("mrst_valid_oe", {30'd0, out_valid, ram_oe}, 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_data", 32'(out_data), 32'd0);
    RST = 1'b0;
    @(negedge CLK);
    chk("mrst_idle", 32'(busy), 32'd0);
    run_vec(vecs[0]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
